// File: rtl/regfile_pkg.sv
// Shared widths and the writeback entry record for the register-file write path.
package regfile_pkg;

  localparam int AW = 5;
  localparam int DW = 32;

  localparam logic [AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

endpackage

// File: rtl/wb_match.sv
// Youngest-first forwarding lookup over the pending FIFO entries plus the output stage.
module wb_match
  import regfile_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  entry_t          fifo [DEPTH],
  input  logic   [PW-1:0] rd_ptr,
  input  logic   [CW-1:0] count,
  input  logic            out_valid,
  input  entry_t          out_ent,
  input  logic   [AW-1:0] q_addr,
  output logic            hit,
  output logic   [DW-1:0] data
);

  logic [PW-1:0] idx;

  // Scan oldest to youngest so each later match overrides an earlier one;
  // the output stage is older than every FIFO entry and is tried first.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = rd_ptr;
    if (q_addr != REG_ZERO) begin
      if (out_valid && out_ent.addr == q_addr) begin
        hit  = 1'b1;
        data = out_ent.data;
      end
      for (int i = 0; i < DEPTH; i++) begin
        idx = rd_ptr + PW'(i);
        if (CW'(i) < count && fifo[idx].addr == q_addr) begin
          hit  = 1'b1;
          data = fifo[idx].data;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_wb_queue.sv
// Writeback queue feeding the register file's single write port, with two forwarding lookups.
module regfile_wb_queue
  import regfile_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_addr,
  input  logic [DW-1:0] in_data,
  output logic          r3_wr,
  output logic [AW-1:0] r3_addr,
  output logic [DW-1:0] r3_din,
  input  logic [AW-1:0] q1_addr,
  output logic          q1_hit,
  output logic [DW-1:0] q1_data,
  input  logic [AW-1:0] q2_addr,
  output logic          q2_hit,
  output logic [DW-1:0] q2_data,
  output logic [CW-1:0] count,
  output logic          empty
);

  entry_t        fifo [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  entry_t        out_q;
  logic          out_valid_q;

  logic push;
  logic pop;

  assign in_ready = (count_q < CW'(DEPTH));
  // Writes to r0 complete the handshake but are dropped here.
  assign push     = in_valid && in_ready && (in_addr != REG_ZERO);
  assign pop      = (count_q != '0);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      out_valid_q <= pop;
      if (pop) out_q <= fifo[rd_ptr];
    end
  end

  // NOTE: storage is not reset; entries are only ever read when count says they are valid.
  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= '{addr: in_addr, data: in_data};
  end

  assign r3_wr   = out_valid_q;
  assign r3_addr = out_q.addr;
  assign r3_din  = out_q.data;
  assign count   = count_q;
  assign empty   = (count_q == '0) && !out_valid_q;

  wb_match #(.DEPTH(DEPTH)) u_match_q1 (
    .fifo      (fifo),
    .rd_ptr    (rd_ptr),
    .count     (count_q),
    .out_valid (out_valid_q),
    .out_ent   (out_q),
    .q_addr    (q1_addr),
    .hit       (q1_hit),
    .data      (q1_data)
  );

  wb_match #(.DEPTH(DEPTH)) u_match_q2 (
    .fifo      (fifo),
    .rd_ptr    (rd_ptr),
    .count     (count_q),
    .out_valid (out_valid_q),
    .out_ent   (out_q),
    .q_addr    (q2_addr),
    .hit       (q2_hit),
    .data      (q2_data)
  );

endmodule
